// File: rtl/systolic_2x2_sequencer_if.sv
// Job, array and result signals shared between the 2x2 systolic sequencer and its environment.
// master = sequencer side, slave = job source / array / result consumer side.
interface systolic_2x2_sequencer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9
);
  logic                    job_valid;
  logic                    job_ready;
  logic [4*DATA_WIDTH-1:0] job_a;
  logic [4*DATA_WIDTH-1:0] job_b;
  logic                    arr_in_valid;
  logic [DATA_WIDTH-1:0]   arr_a00, arr_a01, arr_a10, arr_a11;
  logic [DATA_WIDTH-1:0]   arr_b00, arr_b01, arr_b10, arr_b11;
  logic [ACC_WIDTH-1:0]    arr_c00, arr_c01, arr_c10, arr_c11;
  logic                    res_valid;
  logic                    res_ready;
  logic [4*ACC_WIDTH-1:0]  res_c;
  logic                    busy;

  modport master (
    input  job_valid, job_a, job_b, arr_c00, arr_c01, arr_c10, arr_c11, res_ready,
    output job_ready, arr_in_valid, arr_a00, arr_a01, arr_a10, arr_a11,
           arr_b00, arr_b01, arr_b10, arr_b11, res_valid, res_c, busy
  );

  modport slave (
    output job_valid, job_a, job_b, arr_c00, arr_c01, arr_c10, arr_c11, res_ready,
    input  job_ready, arr_in_valid, arr_a00, arr_a01, arr_a10, arr_a11,
           arr_b00, arr_b01, arr_b10, arr_b11, res_valid, res_c, busy
  );
endinterface

// File: rtl/systolic_2x2_sequencer.sv
// Job-level sequencer for a 2x2 systolic array: skewed operand schedule, fixed-latency
// result capture into a FWFT FIFO, and credit-gated issue so no result is ever dropped.
module systolic_2x2_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9,
  parameter int OUT_DEPTH  = 4,
  parameter int CAP_LAT    = 6
) (
  input logic                      clk,
  input logic                      rst,
  systolic_2x2_sequencer_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int RW = 4 * ACC_WIDTH;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);

  logic            r_job_ready;
  logic [CW-1:0]   r_credits;
  logic [CAP_LAT:0] r_slot;  // bit k set: some job is in slot S_k this cycle
  logic [DW-1:0]   r_b00_d, r_b10_d;
  logic [DW-1:0]   r_b11_d [2];
  logic [DW-1:0]   r_a00_d [2];
  logic [DW-1:0]   r_a01_d [3];
  logic [DW-1:0]   r_a10_d [3];
  logic [DW-1:0]   r_a11_d [4];
  logic            r_in_valid;
  logic [DW-1:0]   r_arr_a00, r_arr_a01, r_arr_a10, r_arr_a11;
  logic [DW-1:0]   r_arr_b00, r_arr_b01, r_arr_b10, r_arr_b11;
  logic [RW-1:0]   r_mem [OUT_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [RW-1:0]   r_res_c;

  logic            w_accept, w_pop, w_capture, w_res_valid;
  logic [CW-1:0]   w_credits_nxt, w_count_nxt;
  logic [PW-1:0]   w_rd_nxt, w_wr_nxt;
  logic [RW-1:0]   w_cap_data;

  assign w_res_valid = (r_count != '0);
  assign w_accept    = bus.job_valid && r_job_ready;
  assign w_pop       = w_res_valid && bus.res_ready;
  assign w_capture   = r_slot[CAP_LAT];
  assign w_cap_data  = {bus.arr_c11, bus.arr_c10, bus.arr_c01, bus.arr_c00};
  assign w_rd_nxt    = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_nxt    = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);

  always_comb begin
    w_credits_nxt = r_credits;
    if (w_accept && !w_pop)      w_credits_nxt = r_credits - CW'(1);
    else if (!w_accept && w_pop) w_credits_nxt = r_credits + CW'(1);
    w_count_nxt = r_count;
    if (w_capture && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_capture && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_ready <= 1'b0;
      r_credits   <= CRED_MAX;
      r_slot      <= '0;
      r_b00_d     <= '0;
      r_b10_d     <= '0;
      for (int k = 0; k < 2; k++) begin
        r_b11_d[k] <= '0;
        r_a00_d[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        r_a01_d[k] <= '0;
        r_a10_d[k] <= '0;
      end
      for (int k = 0; k < 4; k++) r_a11_d[k] <= '0;
      r_in_valid <= 1'b0;
      r_arr_a00  <= '0;
      r_arr_a01  <= '0;
      r_arr_a10  <= '0;
      r_arr_a11  <= '0;
      r_arr_b00  <= '0;
      r_arr_b01  <= '0;
      r_arr_b10  <= '0;
      r_arr_b11  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_res_c    <= '0;
    end else begin
      // Registered ready also enforces the 2-cycle minimum job spacing.
      r_job_ready <= (w_credits_nxt != '0) && !w_accept;
      r_credits   <= w_credits_nxt;
      r_slot      <= {r_slot[CAP_LAT-1:0], w_accept};

      r_b00_d    <= w_accept ? bus.job_b[0*DW +: DW] : '0;
      r_b10_d    <= w_accept ? bus.job_b[2*DW +: DW] : '0;
      r_b11_d[0] <= w_accept ? bus.job_b[3*DW +: DW] : '0;
      r_b11_d[1] <= r_b11_d[0];
      r_a00_d[0] <= w_accept ? bus.job_a[0*DW +: DW] : '0;
      r_a00_d[1] <= r_a00_d[0];
      r_a01_d[0] <= w_accept ? bus.job_a[1*DW +: DW] : '0;
      r_a10_d[0] <= w_accept ? bus.job_a[2*DW +: DW] : '0;
      r_a11_d[0] <= w_accept ? bus.job_a[3*DW +: DW] : '0;
      for (int k = 1; k < 3; k++) begin
        r_a01_d[k] <= r_a01_d[k-1];
        r_a10_d[k] <= r_a10_d[k-1];
      end
      for (int k = 1; k < 4; k++) r_a11_d[k] <= r_a11_d[k-1];

      // Delay lines are zero outside a job's slots, so overlapping jobs never collide.
      r_arr_b01  <= w_accept ? bus.job_b[1*DW +: DW] : '0;
      r_arr_b00  <= r_b00_d;
      r_arr_b10  <= r_b10_d;
      r_arr_b11  <= r_b11_d[1];
      r_arr_a00  <= r_a00_d[1];
      r_arr_a01  <= r_a01_d[2];
      r_arr_a10  <= r_a10_d[2];
      r_arr_a11  <= r_a11_d[3];
      r_in_valid <= |r_slot[4:1];

      if (w_capture) r_wr_ptr <= w_wr_nxt;
      if (w_pop)     r_rd_ptr <= w_rd_nxt;
      r_count <= w_count_nxt;
      // Head register: holds its last value when the FIFO drains.
      if (w_capture && ((r_count == '0) || ((r_count == CW'(1)) && w_pop)))
        r_res_c <= w_cap_data;
      else if (w_pop && (r_count > CW'(1)))
        r_res_c <= r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wr_ptr] <= w_cap_data;
  end

  assign bus.job_ready    = r_job_ready;
  assign bus.arr_in_valid = r_in_valid;
  assign bus.arr_a00      = r_arr_a00;
  assign bus.arr_a01      = r_arr_a01;
  assign bus.arr_a10      = r_arr_a10;
  assign bus.arr_a11      = r_arr_a11;
  assign bus.arr_b00      = r_arr_b00;
  assign bus.arr_b01      = r_arr_b01;
  assign bus.arr_b10      = r_arr_b10;
  assign bus.arr_b11      = r_arr_b11;
  assign bus.res_valid    = w_res_valid;
  assign bus.res_c        = r_res_c;
  assign bus.busy         = (|r_slot) || w_res_valid;
endmodule

// File: tb/tb_systolic_2x2_sequencer.sv
// Bench for systolic_2x2_sequencer: directed jobs, schedule tables, and a result
// scoreboard fed on acceptance and drained by an independent monitor.
module tb_systolic_2x2_sequencer;
  localparam int CAP_LAT = 6;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   n_acc = 0;
  int   run_cnt = 0;
  int   last_run = 0;
  logic [35:0] q[$];
  logic [35:0] exp_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_2x2_sequencer_if #(.DATA_WIDTH(4), .ACC_WIDTH(9)) bus ();

  systolic_2x2_sequencer #(
    .DATA_WIDTH(4), .ACC_WIDTH(9), .OUT_DEPTH(4), .CAP_LAT(CAP_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Array stand-in: result word depends only on the cycle number.
  function automatic logic [35:0] pattern(input int k);
    pattern = {9'(4*k + 3), 9'(4*k + 2), 9'(4*k + 1), 9'(4*k)};
  endfunction

  function automatic logic [31:0] arr_all();
    arr_all = {bus.arr_a11, bus.arr_a10, bus.arr_a01, bus.arr_a00,
               bus.arr_b11, bus.arr_b10, bus.arr_b01, bus.arr_b00};
  endfunction

  function automatic logic [31:0] exp_arr(input logic [15:0] a, input logic [15:0] b, input int s);
    logic [31:0] e;
    e = '0;
    case (s)
      0: e[7:4] = b[7:4];
      1: begin e[3:0] = b[3:0]; e[11:8] = b[11:8]; end
      2: begin e[15:12] = b[15:12]; e[19:16] = a[3:0]; end
      3: begin e[23:20] = a[7:4]; e[27:24] = a[11:8]; end
      4: e[31:28] = a[15:12];
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    {bus.arr_c11, bus.arr_c10, bus.arr_c01, bus.arr_c00} = pattern(cyc);
  end

  // Scoreboard: push on acceptance, pop/compare on every result handshake.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL res_unexpected: got %0h expected none", bus.res_c);
        end else begin
          exp_res = q.pop_front();
          chk("res_c", bus.res_c, exp_res);
        end
      end
      if (bus.job_valid && bus.job_ready) begin
        q.push_back(pattern(cyc + 1 + CAP_LAT));
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.arr_in_valid) run_cnt++;
    else begin
      if (run_cnt != 0) last_run = run_cnt;
      run_cnt = 0;
    end
  end

  task automatic send_job(input logic [15:0] a, input logic [15:0] b);
    logic ok;
    ok = 1'b0;
    bus.job_a = a;
    bus.job_b = b;
    bus.job_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.job_ready;
      @(posedge clk);
      #1;
    end
    bus.job_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errs++;
      $display("FAIL send_timeout: got job_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    @(posedge clk);
    #1;
    if (!idle) begin
      n_checks++;
      n_errs++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  logic [31:0] sched [7] = '{32'h0000_00B0, 32'h0000_0207, 32'h0005_9000,
                             32'h0F50_0000, 32'hE000_0000, 32'h0, 32'h0};
  logic        iv    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1);
  end

  initial begin
    logic [4:0]  hist;
    logic        acc;
    int          nacc, a0;
    logic        seen;

    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_a = '0;
    bus.job_b = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_arr", arr_all(), 0);
    chk("rst_in_valid", bus.arr_in_valid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_c", bus.res_c, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_job_ready", bus.job_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_first_cycle", bus.job_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", bus.job_ready, 1);
    @(posedge clk);
    #1;

    // Single job, hand-computed schedule
    send_job(16'hEF55, 16'h92B7);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("single_arr_S%0d", k), arr_all(), sched[k]);
      chk($sformatf("single_iv_S%0d", k), bus.arr_in_valid, iv[k]);
      if (k == 0) chk("single_busy_S0", bus.busy, 1);
      if (k == 6) chk("single_res_valid_S6", bus.res_valid, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("single_res_valid_S7", bus.res_valid, 1);
    wait_idle();

    // Back-to-back
    bus.job_valid = 1'b1;
    bus.job_a = 16'h1234;
    bus.job_b = 16'h5678;
    nacc = 0;
    hist = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hist[k] = bus.job_ready;
      acc = bus.job_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        bus.job_a = bus.job_a + 16'h1111;
        bus.job_b = bus.job_b + 16'h2222;
        if (nacc == 3) bus.job_valid = 1'b0;
      end
    end
    chk("b2b_ready_pattern", hist, 5'b10101);
    chk("b2b_accepts", nacc, 3);
    wait_idle();
    chk("b2b_in_valid_run", last_run, 8);

    // Backpressure
    bus.res_ready = 1'b0;
    a0 = n_acc;
    bus.job_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      bus.job_a = bus.job_a + 16'h0101;
    end
    chk("bp_accepts", n_acc - a0, 4);
    @(negedge clk);
    chk("bp_ready_low", bus.job_ready, 0);
    chk("bp_busy", bus.busy, 1);
    chk("bp_res_valid", bus.res_valid, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", bus.job_ready, 1);
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    chk("bp_accepts_after_pop", n_acc - a0, 5);
    @(negedge clk);
    chk("bp_ready_refull", bus.job_ready, 0);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    wait_idle();

    // Capture and pop in the same cycle with one stored entry
    bus.res_ready = 1'b0;
    send_job(16'hA1B2, 16'hC3D4);
    send_job(16'h5E6F, 16'h7081);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("sim_one_entry", bus.res_valid, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    chk("sim_still_one", bus.res_valid, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    chk("sim_empty", bus.res_valid, 0);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    wait_idle();

    // Idle gaps: second job 4 cycles after first S0 (5-cycle spacing between acceptances)
    send_job(16'h3C1A, 16'h6D2B);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        bus.job_a = 16'h9E4F;
        bus.job_b = 16'h8071;
        bus.job_valid = 1'b1;
      end
      @(negedge clk);
      if (k < 5) chk($sformatf("gap_arr_%0d", k), arr_all(), exp_arr(16'h3C1A, 16'h6D2B, k));
      else       chk($sformatf("gap_arr_%0d", k), arr_all(), exp_arr(16'h9E4F, 16'h8071, k - 5));
      @(posedge clk);
      #1;
      if (k == 4) bus.job_valid = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus.res_valid;
    end
    chk("gap_last_result_seen", seen, 1);
    chk("gap_busy_at_pop", bus.busy, 1);
    @(negedge clk);
    chk("gap_busy_after_pop", bus.busy, 0);
    chk("gap_res_valid_after_pop", bus.res_valid, 0);
    @(posedge clk);
    #1;

    // Reset mid-job with one stored result
    bus.res_ready = 1'b0;
    send_job(16'h1111, 16'h2222);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    send_job(16'h3333, 16'h4444);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_arr", arr_all(), 0);
    chk("mid_rst_in_valid", bus.arr_in_valid, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_job_ready", bus.job_ready, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_first", bus.job_ready, 0);
    @(negedge clk);
    chk("mid_rst_ready_after", bus.job_ready, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_no_result", bus.res_valid, 0);
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_2x2_sequencer.md
Name: systolic_2x2_sequencer

Overview:
Job-level controller that sequences the 2x2 systolic array datapath. It accepts one matrix pair (A, B) per valid/ready handshake, drives the skewed per-cycle weight/data schedule and in_valid into the array, and captures c00..c11 at a fixed latency into an output result FIFO with a valid/ready handshake. Jobs are pipelined back-to-back at one job per 2 cycles, and issue is credit-gated so no result is ever dropped.

Parameters:
DATA_WIDTH, 4, width of each A/B element
ACC_WIDTH, 9, width of each C element
OUT_DEPTH, 4, result FIFO entries (2..8); also the maximum number of in-flight plus stored jobs
CAP_LAT, 6, cycles from job slot 0 to result capture (legal range 5..15)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  job can be accepted this cycle
job_a  in  4*DATA_WIDTH  {a11,a10,a01,a00}, a00 in LSBs
job_b  in  4*DATA_WIDTH  {b11,b10,b01,b00}, b00 in LSBs
arr_in_valid  out  1  in_valid to the array
arr_a00, arr_a01, arr_a10, arr_a11  out  DATA_WIDTH each  array data inputs
arr_b00, arr_b01, arr_b10, arr_b11  out  DATA_WIDTH each  array weight inputs
arr_c00, arr_c01, arr_c10, arr_c11  in  ACC_WIDTH each  array results
res_valid  out  1  result FIFO non-empty
res_ready  in  1  consumer pops head
res_c  out  4*ACC_WIDTH  {c11,c10,c01,c00} at FIFO head, c00 in LSBs
busy  out  1  any job in flight or any result stored

Behaviour:
- Reset (rst=1 at an edge): all arr_* outputs 0, arr_in_valid 0, res_valid 0, res_c 0, busy 0, job_ready 0. Any in-flight jobs and stored results are discarded. Credits are restored to OUT_DEPTH. Reset has priority over every other event.
- Acceptance: a job is accepted at edge E when job_valid && job_ready. Slot 0 (S0) of that job is the cycle immediately after E.
- job_ready is registered. It is 1 iff (credits > 0) && (no acceptance at the previous edge). This gives a minimum spacing of 2 cycles between jobs. job_ready is 0 in the cycle following any acceptance.
- Credits: decrement on acceptance, increment on result pop (res_valid && res_ready). Both in the same cycle leaves credits unchanged. Credits never exceed OUT_DEPTH and never go below 0.
- Weight schedule, registered outputs:
  - S0: arr_b01 = b01
  - S1: arr_b00 = b00, arr_b10 = b10
  - S2: arr_b11 = b11
- Data schedule:
  - S2: arr_a00 = a00
  - S3: arr_a01 = a01, arr_a10 = a10
  - S4: arr_a11 = a11
- Any arr_a/arr_b port that has no job slot in a cycle drives 0. Overlapping jobs at 2-cycle spacing never collide on one port; the per-job pipelines are ORed, each slot exclusive by construction.
- arr_in_valid = 1 in cycles S2..S5 of any in-flight job (OR over jobs). With 3 jobs back-to-back from S0=0, it is high in cycles 2..9 and low from cycle 10.
- Capture: at the edge ending cycle S0+CAP_LAT, {arr_c11..arr_c00} is written to the result FIFO tail. The credit scheme guarantees the FIFO is never full at a capture.
- Result FIFO is first-word-fall-through. res_c is valid whenever res_valid=1. A pop and a capture in the same cycle are both honoured. When empty, res_c holds its last value.
- busy = any job in S0..S0+CAP_LAT, or FIFO non-empty.
- Consumer stall: with res_ready=0, at most OUT_DEPTH jobs are accepted, then job_ready=0 until a pop.

Test Plan:
- Reset: assert rst for 3 cycles mid-job -> next cycle all arr_* = 0, res_valid=0, busy=0; job_ready=1 one cycle after rst falls.
- Single job: a=(a00=5,a01=5,a10=15,a11=14), b=(b00=7,b01=11,b10=2,b11=9), accepted at edge E:
  - arr_b01=11 at S0; arr_b00=7 and arr_b10=2 at S1; arr_b11=9 and arr_a00=5 at S2; arr_a01=5 and arr_a10=15 at S3; arr_a11=14 at S4.
  - arr_in_valid high S2..S5.
  - Bench drives c=(1,2,3,4) at S6 -> res_valid at S7 with res_c=(1,2,3,4).
- Back-to-back: 3 jobs offered continuously -> accepted every 2 cycles (job_ready toggles 1,0,1,0,1). arr_in_valid high for exactly 8 consecutive cycles. 3 results are returned in order.
- Backpressure: res_ready=0, 6 jobs offered -> exactly 4 accepted and job_ready stays 0. One pop -> job_ready=1 the next eligible cycle. Credits are never exceeded.
- Simultaneous capture and pop with FIFO holding 1 entry -> occupancy stays 1; data is ordered correctly; credits are unchanged.
- Idle gaps: jobs spaced 5 cycles apart -> all unused arr_* ports read 0 between slots; busy falls 1 cycle after the last pop.
